wb_trace_checker: RTL and testbench

//   Consumer end of the CPU debug writeback interface (debug_wb_pc/_rf_wen/_rf_addr/_rf_wdata).

---
 rtl/wb_trace_checker_if.sv | 22 ++
 rtl/wb_trace_checker.sv | 156 +++++++++++++++
 tb/tb_wb_trace_checker.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_checker_if.sv
// CPU debug writeback bus (debug_wb_pc/_rf_wen/_rf_addr/_rf_wdata).
// The cpu drives it through the master modport and the trace checker samples it through the slave modport.
interface wb_trace_checker_if;
    logic [31:0] wb_pc;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;

    modport master (
        output wb_pc,
        output wb_wen,
        output wb_addr,
        output wb_wdata
    );

    modport slave (
        input wb_pc,
        input wb_wen,
        input wb_addr,
        input wb_wdata
    );
endinterface

// File: rtl/wb_trace_checker.sv
// Golden-trace self-check for the CPU debug writeback port.
// Each retired register write is compared against a preloaded table; the checker reports pass/fail, the first mismatch and a no-progress timeout.
module wb_trace_checker #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AW       = 6,
    parameter int unsigned TIMEOUT  = 2048,
    parameter bit          STOP_ERR = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_ld_en,
    input  logic [AW-1:0]        i_ld_idx,
    input  logic [31:0]          i_ld_pc,
    input  logic [4:0]           i_ld_addr,
    input  logic [31:0]          i_ld_data,
    input  logic [AW:0]          i_ld_len,
    input  logic                 i_start,
    wb_trace_checker_if.slave    i_wb,
    output logic                 o_busy,
    output logic                 o_pass,
    output logic                 o_fail,
    output logic                 o_timeout,
    output logic [AW:0]          o_idx,
    output logic [15:0]          o_err_cnt,
    output logic [AW:0]          o_first_err_idx,
    output logic [31:0]          o_first_err_pc
);

    localparam int unsigned WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [68:0]    r_gold [DEPTH];
    logic [68:0]    w_gold_rd;
    logic [68:0]    w_wb_vec;
    logic           w_ev;
    logic           w_match;
    logic [AW:0]    r_idx, w_idx_nxt, w_idx_inc;
    logic [AW:0]    r_len, w_len_nxt;
    logic [WW-1:0]  r_wait, w_wait_nxt;
    logic [15:0]    r_err_cnt, w_err_nxt, w_err_inc;
    logic [AW:0]    r_fe_idx, w_fe_idx_nxt;
    logic [31:0]    r_fe_pc, w_fe_pc_nxt;
    logic           r_timeout, w_timeout_nxt;

    // Table has no reset so a trace loaded once survives later resets.
    always_ff @(posedge clk) begin
        if (i_ld_en && (r_state == S_IDLE)) begin
            r_gold[i_ld_idx] <= {i_ld_pc, i_ld_addr, i_ld_data};
        end
    end

    assign w_gold_rd = r_gold[r_idx[AW-1:0]];
    assign w_wb_vec  = {i_wb.wb_pc, i_wb.wb_addr, i_wb.wb_wdata};
    assign w_ev      = i_wb.wb_wen && (i_wb.wb_addr != 5'd0);
    assign w_match   = (w_wb_vec == w_gold_rd);
    assign w_idx_inc = r_idx + 1'b1;
    assign w_err_inc = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_wait    <= '0;
            r_err_cnt <= '0;
            r_fe_idx  <= '0;
            r_fe_pc   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_len     <= w_len_nxt;
            r_wait    <= w_wait_nxt;
            r_err_cnt <= w_err_nxt;
            r_fe_idx  <= w_fe_idx_nxt;
            r_fe_pc   <= w_fe_pc_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_len_nxt     = r_len;
        w_wait_nxt    = r_wait;
        w_err_nxt     = r_err_cnt;
        w_fe_idx_nxt  = r_fe_idx;
        w_fe_pc_nxt   = r_fe_pc;
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_len_nxt   = i_ld_len;
                    w_idx_nxt   = '0;
                    w_err_nxt   = '0;
                    w_wait_nxt  = '0;
                    w_state_nxt = (i_ld_len == '0) ? S_PASS : S_RUN;
                end
            end

            S_RUN: begin
                if (w_ev) begin
                    // An event in the expiring cycle still counts as progress.
                    w_wait_nxt = '0;
                    if (w_match) begin
                        w_idx_nxt = w_idx_inc;
                        if (w_idx_inc == r_len) begin
                            w_state_nxt = (r_err_cnt != '0) ? S_FAIL : S_PASS;
                        end
                    end else begin
                        w_err_nxt = w_err_inc;
                        if (r_err_cnt == '0) begin
                            w_fe_idx_nxt = r_idx;
                            w_fe_pc_nxt  = i_wb.wb_pc;
                        end
                        if (STOP_ERR) begin
                            w_state_nxt = S_FAIL;
                        end else begin
                            w_idx_nxt = w_idx_inc;
                            if (w_idx_inc == r_len) begin
                                w_state_nxt = S_FAIL;
                            end
                        end
                    end
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                    if (r_wait == WW'(TIMEOUT - 1)) begin
                        w_state_nxt   = S_FAIL;
                        w_timeout_nxt = 1'b1;
                    end
                end
            end

            default: begin
            end
        endcase
    end

    assign o_busy          = (r_state == S_RUN);
    assign o_pass          = (r_state == S_PASS);
    assign o_fail          = (r_state == S_FAIL);
    assign o_timeout       = r_timeout;
    assign o_idx           = r_idx;
    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_idx = r_fe_idx;
    assign o_first_err_pc  = r_fe_pc;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench: two checkers (stop-on-error and count-and-continue, both TIMEOUT=16) share one writeback bus.
// Expected outputs are queued as stimulus is applied and compared at the following negedge.
module tb_wb_trace_checker;
    localparam int unsigned AW = 6;
    localparam int unsigned DA = 0;
    localparam int unsigned DB = 8;
    localparam int unsigned F_BUSY = 0, F_PASS = 1, F_FAIL = 2, F_TMO = 3,
                            F_IDX = 4, F_ERR = 5, F_FEI = 6, F_FEPC = 7;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_idx = '0;
    logic [31:0]   ld_pc = '0;
    logic [4:0]    ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic [AW:0]   ld_len = '0;
    logic          start = 1'b0;

    wb_trace_checker_if bus ();

    logic          a_busy, a_pass, a_fail, a_tmo, b_busy, b_pass, b_fail, b_tmo;
    logic [AW:0]   a_idx, a_fei, b_idx, b_fei;
    logic [15:0]   a_err, b_err;
    logic [31:0]   a_fepc, b_fepc;

    wb_trace_checker #(.DEPTH(64), .AW(AW), .TIMEOUT(16), .STOP_ERR(1'b1)) dut_a (
        .clk(clk), .resetn(resetn),
        .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_pc(ld_pc), .i_ld_addr(ld_addr),
        .i_ld_data(ld_data), .i_ld_len(ld_len), .i_start(start), .i_wb(bus),
        .o_busy(a_busy), .o_pass(a_pass), .o_fail(a_fail), .o_timeout(a_tmo),
        .o_idx(a_idx), .o_err_cnt(a_err), .o_first_err_idx(a_fei), .o_first_err_pc(a_fepc)
    );

    wb_trace_checker #(.DEPTH(64), .AW(AW), .TIMEOUT(16), .STOP_ERR(1'b0)) dut_b (
        .clk(clk), .resetn(resetn),
        .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_pc(ld_pc), .i_ld_addr(ld_addr),
        .i_ld_data(ld_data), .i_ld_len(ld_len), .i_start(start), .i_wb(bus),
        .o_busy(b_busy), .o_pass(b_pass), .o_fail(b_fail), .o_timeout(b_tmo),
        .o_idx(b_idx), .o_err_cnt(b_err), .o_first_err_idx(b_fei), .o_first_err_pc(b_fepc)
    );

    logic [31:0] g_pc   [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
    logic [4:0]  g_addr [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
    logic [31:0] g_data [4] = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};

    typedef struct {
        string       tag;
        int unsigned fld;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] actual(input int unsigned f);
        case (f)
            DA + F_BUSY: return {31'd0, a_busy};
            DA + F_PASS: return {31'd0, a_pass};
            DA + F_FAIL: return {31'd0, a_fail};
            DA + F_TMO:  return {31'd0, a_tmo};
            DA + F_IDX:  return 32'(a_idx);
            DA + F_ERR:  return 32'(a_err);
            DA + F_FEI:  return 32'(a_fei);
            DA + F_FEPC: return a_fepc;
            DB + F_BUSY: return {31'd0, b_busy};
            DB + F_PASS: return {31'd0, b_pass};
            DB + F_FAIL: return {31'd0, b_fail};
            DB + F_TMO:  return {31'd0, b_tmo};
            DB + F_IDX:  return 32'(b_idx);
            DB + F_ERR:  return 32'(b_err);
            DB + F_FEI:  return 32'(b_fei);
            DB + F_FEPC: return b_fepc;
            default:     return 32'hXXXX_XXXX;
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned fld, input int unsigned v);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic expect_st(input string tag, input int unsigned d, input int unsigned b,
                             input int unsigned p, input int unsigned f, input int unsigned t,
                             input int unsigned ix, input int unsigned ec);
        string pfx;
        pfx = {tag, (d == DA) ? ".a" : ".b"};
        push({pfx, ".busy"}, d + F_BUSY, b);
        push({pfx, ".pass"}, d + F_PASS, p);
        push({pfx, ".fail"}, d + F_FAIL, f);
        push({pfx, ".timeout"}, d + F_TMO, t);
        push({pfx, ".idx"}, d + F_IDX, ix);
        push({pfx, ".err_cnt"}, d + F_ERR, ec);
    endtask

    task automatic expect_fe(input string tag, input int unsigned d, input int unsigned fei,
                             input int unsigned fepc);
        string pfx;
        pfx = {tag, (d == DA) ? ".a" : ".b"};
        push({pfx, ".first_err_idx"}, d + F_FEI, fei);
        push({pfx, ".first_err_pc"}, d + F_FEPC, fepc);
    endtask

    task automatic expect_both(input string tag, input int unsigned b, input int unsigned p,
                               input int unsigned f, input int unsigned t, input int unsigned ix,
                               input int unsigned ec);
        expect_st(tag, DA, b, p, f, t, ix, ec);
        expect_st(tag, DB, b, p, f, t, ix, ec);
    endtask

    task automatic drain();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, actual(e.fld), e.exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic do_load(input int unsigned i, input logic [31:0] pc, input logic [4:0] a,
                           input logic [31:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = AW'(i); ld_pc = pc; ld_addr = a; ld_data = d;
        @(posedge clk); #1 ld_en = 1'b0;
    endtask

    task automatic do_start(input int unsigned len);
        @(posedge clk); #1;
        start = 1'b1; ld_len = (AW + 1)'(len);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_wb(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.wb_wen = 1'b1; bus.wb_pc = pc; bus.wb_addr = a; bus.wb_wdata = d;
        @(posedge clk); #1 bus.wb_wen = 1'b0;
    endtask

    task automatic wb_entry(input int unsigned i);
        do_wb(g_pc[i], g_addr[i], g_data[i]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.wb_wen = 1'b0; bus.wb_pc = '0; bus.wb_addr = '0; bus.wb_wdata = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        expect_both("reset", 0, 0, 0, 0, 0, 0);
        expect_fe("reset", DA, 0, 0);
        expect_fe("reset", DB, 0, 0);
        drain();

        // Clean trace with a $0 write injected between entries 1 and 2.
        for (int unsigned i = 0; i < 4; i++) do_load(i, g_pc[i], g_addr[i], g_data[i]);
        do_start(4);
        expect_both("run0", 1, 0, 0, 0, 0, 0);
        drain();
        wb_entry(0);
        wb_entry(1);
        expect_both("wb1", 1, 0, 0, 0, 2, 0);
        drain();
        do_wb(32'd6, 5'd0, 32'h55);
        expect_both("wb_r0", 1, 0, 0, 0, 2, 0);
        drain();
        wb_entry(2);
        expect_both("wb2", 1, 0, 0, 0, 3, 0);
        drain();
        wb_entry(3);
        expect_both("pass", 0, 1, 0, 0, 4, 0);
        drain();
        wb_entry(0);
        expect_both("frozen", 0, 1, 0, 0, 4, 0);
        drain();

        // Entry 2 expects data 4 but the cpu writes 3.
        do_reset();
        do_load(2, 32'd8, 5'd3, 32'd4);
        do_start(4);
        wb_entry(0);
        wb_entry(1);
        wb_entry(2);
        expect_st("mis", DA, 0, 0, 1, 0, 2, 1);
        expect_fe("mis", DA, 2, 8);
        expect_st("mis", DB, 1, 0, 0, 0, 3, 1);
        expect_fe("mis", DB, 2, 8);
        drain();
        wb_entry(3);
        expect_st("mis_end", DA, 0, 0, 1, 0, 2, 1);
        expect_st("mis_end", DB, 0, 0, 1, 0, 4, 1);
        expect_fe("mis_end", DB, 2, 8);
        drain();

        // Restore entry 2; ld_en during RUN must not touch the table; reset at idx=2.
        do_reset();
        do_load(2, 32'd8, 5'd3, 32'd3);
        do_start(4);
        do_load(0, 32'hDEAD_BEEF, 5'd9, 32'h1234);
        wb_entry(0);
        wb_entry(1);
        expect_both("pre_rst", 1, 0, 0, 0, 2, 0);
        drain();
        do_reset();
        expect_both("mid_rst", 0, 0, 0, 0, 0, 0);
        drain();
        do_start(4);
        for (int unsigned i = 0; i < 4; i++) wb_entry(i);
        expect_both("restart", 0, 1, 0, 0, 4, 0);
        drain();

        // Timeout exactly 16 clocks after start is accepted.
        do_reset();
        do_start(4);
        repeat (15) @(posedge clk);
        expect_both("tmo15", 1, 0, 0, 0, 0, 0);
        drain();
        @(posedge clk);
        expect_both("tmo16", 0, 0, 1, 1, 0, 0);
        drain();

        // Event in the expiring cycle beats the timeout and restarts the count.
        do_reset();
        do_start(4);
        repeat (15) @(posedge clk);
        #1;
        bus.wb_wen = 1'b1; bus.wb_pc = g_pc[0]; bus.wb_addr = g_addr[0]; bus.wb_wdata = g_data[0];
        @(posedge clk); #1 bus.wb_wen = 1'b0;
        expect_both("ev_wins", 1, 0, 0, 0, 1, 0);
        drain();
        repeat (15) @(posedge clk);
        expect_both("tmo2_15", 1, 0, 0, 0, 1, 0);
        drain();
        @(posedge clk);
        expect_both("tmo2_16", 0, 0, 1, 1, 1, 0);
        drain();

        // Zero-length trace passes on the start edge.
        do_reset();
        do_start(0);
        expect_both("len0", 0, 1, 0, 0, 0, 0);
        drain();
        do_start(4);
        expect_both("len0_nostart", 0, 1, 0, 0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
